// File: rtl/ibex_msg_pkg.sv
// Shared types for the register-file message write sequencer.
package ibex_msg_pkg;

   localparam int MsgMaxWords = 4;

   typedef logic [1:0] msg_len_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } msg_seq_state_e;

endpackage

// File: rtl/ibex_msg_wr_seq.sv
// Writes a 1-4 word message into consecutive register-file message slots,
// one word per cycle, yielding to core writeback whenever it is active.
module ibex_msg_wr_seq
   import ibex_msg_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 5,
   parameter int MaxWords  = MsgMaxWords
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [AddrWidth-1:0]          req_addr_i,
   input  logic [1:0]                    req_len_i,
   input  logic [MaxWords*DataWidth-1:0] req_data_i,
   input  logic                          core_we_i,
   input  logic                          flush_i,
   output logic                          rf_valid_o,
   output logic [AddrWidth-1:0]          rf_addr_o,
   output logic [DataWidth-1:0]          rf_data_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o
);

   msg_seq_state_e                state_q, state_d;
   logic [AddrWidth-1:0]          addr_q, addr_d;
   msg_len_t                      len_q, len_d;
   msg_len_t                      idx_q, idx_d;
   logic [MaxWords*DataWidth-1:0] data_q, data_d;
   logic                          err_q, err_d;

   logic [AddrWidth:0] req_end;
   logic               req_legal;
   logic               accept;
   logic               wr_fire;

   // One extra bit so base + len can never wrap back into a legal range.
   assign req_end   = {1'b0, req_addr_i} + (AddrWidth+1)'(req_len_i);
   assign req_legal = (req_addr_i != '0) && (req_end <= {1'b0, {AddrWidth{1'b1}}});

   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign wr_fire     = (state_q == WRITE) && !core_we_i && !flush_i;

   assign rf_valid_o = wr_fire;
   assign rf_addr_o  = addr_q + AddrWidth'(idx_q);
   assign busy_o     = (state_q != IDLE);
   assign done_o     = (state_q == DONE);
   assign err_o      = err_q;

   always_comb begin
      rf_data_o = data_q[DataWidth-1:0];
      for (int w = 1; w < MaxWords; w++) begin
         if (idx_q == msg_len_t'(w)) rf_data_o = data_q[w*DataWidth +: DataWidth];
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default up front so no path leaves one unassigned, which would infer a latch.
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      idx_d   = idx_q;
      data_d  = data_q;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d = req_addr_i;
               len_d  = req_len_i;
               data_d = req_data_i;
               idx_d  = '0;
               if (req_legal) state_d = WRITE;
               else           err_d   = 1'b1;
            end
         end
         WRITE: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (wr_fire) begin
               if (idx_q == len_q) state_d = DONE;
               else                idx_d   = idx_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/ibex_msg_wr_seq.md
# ibex_msg_wr_seq

Message write sequencer for the flop-based register file's message bank. It accepts one multi-word message (1–4 words) per valid/ready handshake and writes the words into consecutive message slots, one word per cycle. It drives the register file's `input_valid` / `input_addr` / `input_data` port. Core writeback has priority: any cycle with a core write enable stalls the sequence.

## Interface
Parameters:
- `DataWidth`, 32: word width.
- `AddrWidth`, 5: slot address width (4 for RV32E).
- `MaxWords`, 4: maximum message length in words.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: message request valid.
- `req_ready_o` out 1: sequencer can accept a request.
- `req_addr_i` in AddrWidth: base slot address.
- `req_len_i` in 2: word count minus 1 (0 means 1 word, 3 means 4 words).
- `req_data_i` in MaxWords*DataWidth: packed words, word 0 in the LSBs.
- `core_we_i` in 1: core register-file write this cycle; stalls the sequencer.
- `flush_i` in 1: abort the current message.
- `rf_valid_o` out 1: to the register file `input_valid`.
- `rf_addr_o` out AddrWidth: to `input_addr`.
- `rf_data_o` out DataWidth: to `input_data`.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle pulse when a message completes.
- `err_o` out 1: one-cycle pulse when a request is rejected.

## Operation
- FSM states: IDLE, WRITE, DONE.
- Reset (`rst_i`=1 at a clock edge):
  - state becomes IDLE; word index, count and data registers clear to 0.
  - `err_o` and `done_o` are 0.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i && req_ready_o`, latch addr, len and all words.
  - Request is legal iff `req_addr_i != 0` and `req_addr_i + req_len_i <= 2**AddrWidth - 1`. The check uses AddrWidth+1-bit arithmetic, so there is no wrap-around.
  - Legal request: go to WRITE with index 0.
  - Illegal request: stay in IDLE, pulse `err_o` the next cycle, make no writes.
- WRITE:
  - `rf_valid_o = !core_we_i && !flush_i`.
  - `rf_addr_o` = base + index (no wrap is possible after the legality check).
  - `rf_data_o` = latched word[index].
  - The index increments only on cycles where `rf_valid_o`=1.
  - When the index equals len and that word is written, go to DONE.
- DONE: pulse `done_o`=1, `req_ready_o`=0, return to IDLE.
- `flush_i` in WRITE:
  - Same cycle: `rf_valid_o` is forced to 0.
  - Next state is IDLE; no `done_o` pulse.
  - Words already written stay written.
  - `flush_i` is ignored in IDLE and DONE.
- `req_ready_o` is 0 in WRITE and DONE, and while `rst_i` is asserted.
- Outside WRITE, `rf_valid_o`=0, and `rf_addr_o`/`rf_data_o` hold their last driven values (value is don't-care for checking).
- Simultaneous `core_we_i` and `flush_i`: flush wins, and the sequencer goes to IDLE.

## Timing
- Request accepted at cycle T: the first write is visible in cycle T+1.
- With no stalls, word k is written at T+1+k.
- `done_o` pulses at T+len+2; IDLE (ready) again at T+len+3.
- Each `core_we_i` cycle during WRITE adds exactly one cycle of latency.
- Back-to-back throughput: one message per (words + 2) cycles.
- Illegal request: `err_o` pulses at T+1 and `req_ready_o` stays 1, so a new request can be accepted at T+1.
- Reset mid-WRITE: no `rf_valid_o` in the cycle after the reset edge.
- `rf_*` outputs are combinational from state and `core_we_i`/`flush_i`; all other outputs are registered.

## Structure
- Shared package `ibex_msg_pkg` holds:
  - `msg_seq_state_e` (IDLE/WRITE/DONE).
  - `MsgMaxWords`.
  - `msg_len_t` (2-bit).
- No sub-module is needed. Word selection is an index mux over the latched packed data.
- The block instantiates next to the register file. `core_we_i` ties to the register file's `we_a_i`.

## Test plan
- Single-word write: addr=5, len=0, data=0xDEADBEEF -> one `rf_valid_o` with addr 5, data 0xDEADBEEF at T+1; `done_o` at T+2.
- Four-word write: addr=28, len=3, data 0x11/0x22/0x33/0x44 -> writes to 28,29,30,31 on T+1..T+4; `done_o` at T+5.
- Stall: addr=10, len=2, `core_we_i`=1 at T+2 -> writes at 10@T+1, 11@T+3, 12@T+4; `done_o` at T+5.
- Illegal requests -> `err_o` at T+1, no `rf_valid_o`, `req_ready_o` stays 1:
  - addr=30, len=2
  - addr=0, len=0
- Flush: addr=3, len=3, `flush_i` at T+2 -> only slot 3 written; IDLE at T+3; no `done_o`.
- Reset mid-WRITE at T+2 -> no further writes; `req_ready_o`=1 after `rst_i` deasserts; next request executes normally.
